// File: rtl/trex_pkg.sv
// Shared types, hit-box sizes and parameter defaults for the T-Rex controller.
// frame_for maps a (next) state plus the frame timer onto its animation frame.
package trex_pkg;

  typedef enum logic [2:0] {
    WAITING,
    RUNNING,
    JUMPING,
    DUCKING,
    CRASHED
  } state_t;

  typedef enum logic [2:0] {
    WAITING0,
    WAITING1,
    RUNNING0,
    RUNNING1,
    JUMPING0,
    DUCKING0,
    DUCKING1,
    CRASHED0
  } frame_t;

  localparam logic [6:0] STAND_BOX_W = 7'd44;
  localparam logic [5:0] STAND_BOX_H = 6'd47;
  localparam logic [6:0] DUCK_BOX_W  = 7'd59;
  localparam logic [5:0] DUCK_BOX_H  = 6'd25;

  localparam int DEF_POS_W          = 10;
  localparam int DEF_VEL_W          = 8;
  localparam int DEF_START_X        = 50;
  localparam int DEF_GROUND_Y       = 93;
  localparam int DEF_MAX_JUMP_Y     = 30;
  localparam int DEF_MIN_JUMP_H     = 30;
  localparam int DEF_GRAVITY        = 6;
  localparam int DEF_INIT_JUMP_VEL  = -10;
  localparam int DEF_DROP_VEL       = -5;
  localparam int DEF_SPEED_DROP_VEL = 6;
  localparam int DEF_RUN_PERIOD     = 10;
  localparam int DEF_DUCK_PERIOD    = 20;

  // The waiting sprite blinks on the second half-second of each 60-frame cycle.
  localparam int BLINK_TIMER = 30;

  // Gravity is accumulated in tenths of a pixel per tick squared.
  localparam int ACC_WRAP = 10;

  function automatic frame_t frame_for(state_t s, logic [5:0] timer,
                                       int run_period, int duck_period);
    frame_t f;
    f = CRASHED0;
    case (s)
      WAITING: f = (int'(timer) >= BLINK_TIMER) ? WAITING0 : WAITING1;
      RUNNING: f = ((int'(timer) % run_period) < (run_period / 2)) ? RUNNING0 : RUNNING1;
      DUCKING: f = ((int'(timer) % duck_period) < (duck_period / 2)) ? DUCKING0 : DUCKING1;
      JUMPING: f = JUMPING0;
      default: f = CRASHED0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/trex_ctrl_if.sv
// Game-side bundle of the T-Rex controller: per-frame inputs and sprite outputs.
// The game loop is the master; trex_ctrl is the slave.
interface trex_ctrl_if import trex_pkg::*; #(
  parameter int POS_W = DEF_POS_W
);

  logic             frame_tick;
  logic [5:0]       timer;
  logic [3:0]       speed;
  logic             jump;
  logic             duck;
  logic             crash;
  logic             restart;
  logic [POS_W-1:0] x_pos;
  logic [POS_W-1:0] y_pos;
  frame_t           frame;
  state_t           state;
  logic [6:0]       box_w;
  logic [5:0]       box_h;

  modport master (
    output frame_tick, timer, speed, jump, duck, crash, restart,
    input  x_pos, y_pos, frame, state, box_w, box_h
  );

  modport slave (
    input  frame_tick, timer, speed, jump, duck, crash, restart,
    output x_pos, y_pos, frame, state, box_w, box_h
  );

endinterface

// File: rtl/trex_physics.sv
// Vertical motion of the T-Rex: height, signed velocity, gravity accumulator and
// the minimum-height flag, driven by one-hot strobes that are already frame-gated.
module trex_physics import trex_pkg::*; #(
  parameter int POS_W          = DEF_POS_W,
  parameter int VEL_W          = DEF_VEL_W,
  parameter int GROUND_Y       = DEF_GROUND_Y,
  parameter int MAX_JUMP_Y     = DEF_MAX_JUMP_Y,
  parameter int MIN_JUMP_H     = DEF_MIN_JUMP_H,
  parameter int GRAVITY        = DEF_GRAVITY,
  parameter int DROP_VEL       = DEF_DROP_VEL,
  parameter int SPEED_DROP_VEL = DEF_SPEED_DROP_VEL
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    launch,
  input  logic                    step,
  input  logic                    drop,
  input  logic                    fastfall,
  input  logic                    freeze,
  input  logic                    land,
  input  logic signed [VEL_W-1:0] launch_vel,
  output logic        [POS_W-1:0] y,
  output logic signed [VEL_W-1:0] vel,
  output logic                    high_enough,
  output logic                    at_max,
  output logic                    ground_hit
);

  logic [3:0]              acc;
  logic                    reached_min;
  logic signed [POS_W:0]   vel_ext;
  logic signed [POS_W:0]   y_sum;
  logic [4:0]              acc_sum;
  logic                    acc_carry;
  logic                    below_min;

  assign vel_ext     = {{(POS_W + 1 - VEL_W){vel[VEL_W-1]}}, vel};
  assign y_sum       = $signed({1'b0, y}) + vel_ext;
  assign acc_sum     = {1'b0, acc} + 5'(GRAVITY);
  assign acc_carry   = (acc_sum >= 5'(ACC_WRAP));
  assign below_min   = (int'(y) < (GROUND_Y - MIN_JUMP_H));
  assign high_enough = reached_min | below_min;
  assign at_max      = (int'(y) <= MAX_JUMP_Y);
  assign ground_hit  = (int'(y_sum) >= GROUND_Y);

  // Fast-fall beats the release/max-height cut, which beats the gravity carry.
  // A negative sum can only come from an out-of-range parameter set, so it pins at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y           <= POS_W'(GROUND_Y);
      vel         <= '0;
      acc         <= '0;
      reached_min <= 1'b0;
    end else if (!freeze) begin
      if (land) begin
        y           <= POS_W'(GROUND_Y);
        vel         <= '0;
        acc         <= '0;
        reached_min <= 1'b0;
      end else if (launch) begin
        vel         <= launch_vel;
        acc         <= '0;
        reached_min <= 1'b0;
      end else if (step) begin
        y           <= y_sum[POS_W] ? '0 : y_sum[POS_W-1:0];
        acc         <= acc_carry ? 4'(acc_sum - 5'(ACC_WRAP)) : acc_sum[3:0];
        reached_min <= high_enough;
        if (fastfall) begin
          vel <= VEL_W'(SPEED_DROP_VEL);
        end else if (drop) begin
          vel <= VEL_W'(DROP_VEL);
        end else if (acc_carry) begin
          vel <= vel + VEL_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/trex_ctrl.sv
// T-Rex game controller: per-frame state machine plus registered sprite outputs,
// with vertical motion delegated to trex_physics.
module trex_ctrl import trex_pkg::*; #(
  parameter int POS_W          = DEF_POS_W,
  parameter int VEL_W          = DEF_VEL_W,
  parameter int START_X        = DEF_START_X,
  parameter int GROUND_Y       = DEF_GROUND_Y,
  parameter int MAX_JUMP_Y     = DEF_MAX_JUMP_Y,
  parameter int MIN_JUMP_H     = DEF_MIN_JUMP_H,
  parameter int GRAVITY        = DEF_GRAVITY,
  parameter int INIT_JUMP_VEL  = DEF_INIT_JUMP_VEL,
  parameter int DROP_VEL       = DEF_DROP_VEL,
  parameter int SPEED_DROP_VEL = DEF_SPEED_DROP_VEL,
  parameter int RUN_PERIOD     = DEF_RUN_PERIOD,
  parameter int DUCK_PERIOD    = DEF_DUCK_PERIOD
) (
  input  logic        clk,
  input  logic        rst_n,
  trex_ctrl_if.slave  bus
);

  state_t                  state;
  state_t                  next_state;
  frame_t                  frame;
  logic [6:0]              box_w;
  logic [5:0]              box_h;
  logic                    launch;
  logic                    step;
  logic                    drop;
  logic                    fastfall;
  logic                    freeze;
  logic                    land;
  logic signed [VEL_W-1:0] launch_vel;
  logic [POS_W-1:0]        y;
  logic signed [VEL_W-1:0] vel;
  logic                    high_enough;
  logic                    at_max;
  logic                    ground_hit;

  // Every speed step of 8 adds one pixel per tick to the launch.
  assign launch_vel = VEL_W'(INIT_JUMP_VEL - int'(bus.speed >> 3));

  // Next state and physics strobes; nothing moves unless this is a frame tick.
  // A crash while on the field overrides every other transition that tick.
  always_comb begin
    next_state = state;
    launch     = 1'b0;
    step       = 1'b0;
    drop       = 1'b0;
    fastfall   = 1'b0;
    freeze     = 1'b0;
    land       = 1'b0;
    if (bus.frame_tick) begin
      case (state)
        WAITING: begin
          if (bus.jump) begin
            next_state = JUMPING;
            launch     = 1'b1;
          end
        end
        RUNNING: begin
          if (bus.crash) begin
            next_state = CRASHED;
            freeze     = 1'b1;
          end else if (bus.jump) begin
            next_state = JUMPING;
            launch     = 1'b1;
          end else if (bus.duck) begin
            next_state = DUCKING;
          end
        end
        DUCKING: begin
          if (bus.crash) begin
            next_state = CRASHED;
            freeze     = 1'b1;
          end else if (!bus.duck) begin
            next_state = RUNNING;
          end
        end
        JUMPING: begin
          if (bus.crash) begin
            next_state = CRASHED;
            freeze     = 1'b1;
          end else if (ground_hit) begin
            next_state = bus.duck ? DUCKING : RUNNING;
            land       = 1'b1;
          end else begin
            step     = 1'b1;
            fastfall = bus.duck && (int'(vel) < SPEED_DROP_VEL);
            drop     = ((!bus.jump && high_enough) || at_max) && (int'(vel) < DROP_VEL);
          end
        end
        CRASHED: begin
          if (bus.restart) begin
            next_state = RUNNING;
            land       = 1'b1;
          end
        end
        default: next_state = WAITING;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAITING;
      frame <= WAITING0;
      box_w <= STAND_BOX_W;
      box_h <= STAND_BOX_H;
    end else if (bus.frame_tick) begin
      state <= next_state;
      frame <= frame_for(next_state, bus.timer, RUN_PERIOD, DUCK_PERIOD);
      box_w <= (next_state == DUCKING) ? DUCK_BOX_W : STAND_BOX_W;
      box_h <= (next_state == DUCKING) ? DUCK_BOX_H : STAND_BOX_H;
    end
  end

  trex_physics #(
    .POS_W          (POS_W),
    .VEL_W          (VEL_W),
    .GROUND_Y       (GROUND_Y),
    .MAX_JUMP_Y     (MAX_JUMP_Y),
    .MIN_JUMP_H     (MIN_JUMP_H),
    .GRAVITY        (GRAVITY),
    .DROP_VEL       (DROP_VEL),
    .SPEED_DROP_VEL (SPEED_DROP_VEL)
  ) u_physics (
    .clk         (clk),
    .rst_n       (rst_n),
    .launch      (launch),
    .step        (step),
    .drop        (drop),
    .fastfall    (fastfall),
    .freeze      (freeze),
    .land        (land),
    .launch_vel  (launch_vel),
    .y           (y),
    .vel         (vel),
    .high_enough (high_enough),
    .at_max      (at_max),
    .ground_hit  (ground_hit)
  );

  assign bus.x_pos = POS_W'(START_X);
  assign bus.y_pos = y;
  assign bus.state = state;
  assign bus.frame = frame;
  assign bus.box_w = box_w;
  assign bus.box_h = box_h;

endmodule

// File: tb/tb_trex_ctrl.sv
// Bench for trex_ctrl: directed jump scenarios plus randomized play, all checked
// against a frame-level behavioural model of the T-Rex rules.
module tb_trex_ctrl;
  import trex_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   failures;

  trex_ctrl_if #(.POS_W(10)) bus ();

  trex_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  state_t m_state;
  frame_t m_frame;
  int     m_y;
  int     m_vel;
  int     m_acc;
  bit     m_min;
  int     m_bw;
  int     m_bh;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_state = WAITING;
    m_frame = WAITING0;
    m_y     = 93;
    m_vel   = 0;
    m_acc   = 0;
    m_min   = 1'b0;
    m_bw    = 44;
    m_bh    = 47;
  endtask

  function automatic frame_t exp_frame(state_t s, int t);
    case (s)
      WAITING: return (t >= 30) ? WAITING0 : WAITING1;
      RUNNING: return ((t % 10) < 5) ? RUNNING0 : RUNNING1;
      DUCKING: return ((t % 20) < 10) ? DUCKING0 : DUCKING1;
      JUMPING: return JUMPING0;
      default: return CRASHED0;
    endcase
  endfunction

  task automatic model_launch(input int spd);
    m_state = JUMPING;
    m_vel   = -10 - (spd / 8);
    m_acc   = 0;
    m_min   = 1'b0;
  endtask

  // One game frame of the T-Rex rules, in whole pixels and tenths of gravity.
  task automatic model_tick(input bit j, input bit d, input bit c, input bit r,
                            input int spd, input int tmr);
    int sum;
    int nv;
    bit high;
    bit carry;
    bit on_field;
    on_field = (m_state == RUNNING) || (m_state == JUMPING) || (m_state == DUCKING);
    if (c && on_field) begin
      m_state = CRASHED;
    end else begin
      case (m_state)
        WAITING: if (j) model_launch(spd);
        RUNNING: begin
          if (j) model_launch(spd);
          else if (d) m_state = DUCKING;
        end
        DUCKING: if (!d) m_state = RUNNING;
        CRASHED: begin
          if (r) begin
            m_state = RUNNING;
            m_y = 93;
            m_vel = 0;
            m_acc = 0;
          end
        end
        default: begin
          sum = m_y + m_vel;
          if (sum >= 93) begin
            m_y = 93;
            m_vel = 0;
            m_acc = 0;
            m_state = d ? DUCKING : RUNNING;
          end else begin
            high  = m_min || (m_y < 63);
            m_acc = m_acc + 6;
            carry = (m_acc >= 10);
            if (carry) m_acc = m_acc - 10;
            if (d && m_vel < 6) nv = 6;
            else if (((!j && high) || m_y <= 30) && m_vel < -5) nv = -5;
            else nv = m_vel + (carry ? 1 : 0);
            m_min = high;
            m_y   = (sum < 0) ? 0 : sum;
            m_vel = nv;
          end
        end
      endcase
    end
    m_frame = exp_frame(m_state, tmr);
    m_bw = (m_state == DUCKING) ? 59 : 44;
    m_bh = (m_state == DUCKING) ? 25 : 47;
  endtask

  task automatic compare_all(input string tag);
    checkOutput({tag, ".state"}, int'(bus.state), int'(m_state));
    checkOutput({tag, ".frame"}, int'(bus.frame), int'(m_frame));
    checkOutput({tag, ".y_pos"}, int'(bus.y_pos), m_y);
    checkOutput({tag, ".x_pos"}, int'(bus.x_pos), 50);
    checkOutput({tag, ".box_w"}, int'(bus.box_w), m_bw);
    checkOutput({tag, ".box_h"}, int'(bus.box_h), m_bh);
    checkOutput({tag, ".vel"}, int'(dut.u_physics.vel), m_vel);
  endtask

  task automatic applyStimulus(input bit j, input bit d, input bit c, input bit r,
                               input int spd, input int tmr);
    @(negedge clk);
    bus.jump       = j;
    bus.duck       = d;
    bus.crash      = c;
    bus.restart    = r;
    bus.speed      = 4'(spd);
    bus.timer      = 6'(tmr);
    bus.frame_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    model_tick(j, d, c, r, spd, tmr);
    compare_all("tick");
  endtask

  // Inputs wiggle freely between ticks; the outputs must not move.
  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.jump    = 1'($urandom);
      bus.duck    = 1'($urandom);
      bus.crash   = 1'($urandom);
      bus.restart = 1'($urandom);
      bus.speed   = 4'($urandom);
      bus.timer   = 6'($urandom_range(0, 59));
      @(posedge clk);
      #1;
      compare_all("idle");
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_reset");
    checkOutput("async_reset.acc", int'(dut.u_physics.acc), 0);
    checkOutput("async_reset.reached_min", int'(dut.u_physics.reached_min), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_y[4];
    int n;
    exp_y = '{83, 73, 64, 55};
    tests = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.frame_tick = 1'b0;
    bus.jump = 1'b0;
    bus.duck = 1'b0;
    bus.crash = 1'b0;
    bus.restart = 1'b0;
    bus.speed = '0;
    bus.timer = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    checkOutput("reset.acc", int'(dut.u_physics.acc), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Waiting-frame blink boundary, then a held jump at speed 0 and its release.
    applyStimulus(0, 0, 0, 0, 0, 29);
    applyStimulus(0, 0, 1, 1, 0, 30);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("launch_speed0.vel", int'(dut.u_physics.vel), -10);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("held_jump.y", int'(bus.y_pos), exp_y[i]);
    end
    checkOutput("held_jump.vel", int'(dut.u_physics.vel), -8);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("release.y", int'(bus.y_pos), 47);
    checkOutput("release.vel", int'(dut.u_physics.vel), -5);

    // Crash mid-air freezes height; restart drops back to the ground running.
    pulse_reset();
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 7);
    checkOutput("crash.state", int'(bus.state), int'(CRASHED));
    checkOutput("crash.y", int'(bus.y_pos), 55);
    checkOutput("crash.frame", int'(bus.frame), int'(CRASHED0));
    applyStimulus(1, 1, 0, 0, 0, 7);
    applyStimulus(0, 0, 0, 1, 0, 3);
    checkOutput("restart.state", int'(bus.state), int'(RUNNING));
    checkOutput("restart.y", int'(bus.y_pos), 93);
    foreach (exp_y[i]) applyStimulus(0, 0, 0, 1, 0, 4 + i);
    applyStimulus(0, 1, 0, 0, 0, 9);
    applyStimulus(0, 1, 0, 0, 0, 10);
    applyStimulus(1, 1, 0, 0, 0, 19);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Fast launch, fast-fall from -7 and a ducked landing.
    pulse_reset();
    applyStimulus(1, 0, 0, 0, 8, 0);
    checkOutput("launch_speed8.vel", int'(dut.u_physics.vel), -11);
    for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 0, 8, 0);
    checkOutput("pre_duck.vel", int'(dut.u_physics.vel), -7);
    applyStimulus(0, 1, 0, 0, 8, 0);
    checkOutput("fastfall.vel", int'(dut.u_physics.vel), 6);
    n = 0;
    while (m_state == JUMPING && n < 40) begin
      applyStimulus(0, 1, 0, 0, 8, 12);
      n++;
    end
    checkOutput("landing_within_budget", int'(n < 40), 1);
    checkOutput("duck_land.state", int'(bus.state), int'(DUCKING));
    checkOutput("duck_land.y", int'(bus.y_pos), 93);
    checkOutput("duck_land.box_w", int'(bus.box_w), 59);
    checkOutput("duck_land.box_h", int'(bus.box_h), 25);

    // Reset mid-jump between ticks, then idle cycles with no tick.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0);
    idle_cycles(2);
    pulse_reset();
    idle_cycles(4);
    applyStimulus(1, 0, 0, 0, 15, 40);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset();
      applyStimulus($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 30,
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 59)));
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/trex_ctrl.md
TREX_CTRL -- requirements
Module: trex_ctrl

Interface
REQ-001 Parameter POS_W, 10: width of x_pos/y_pos.
REQ-002 Parameter VEL_W, 8: width of signed vertical velocity.
REQ-003 Parameter START_X, 50: x_pos value.
REQ-004 Parameter GROUND_Y, 93: y_pos on the ground.
REQ-005 Parameter MAX_JUMP_Y, 30: y at or above which a jump is cut to DROP_VEL.
REQ-006 Parameter MIN_JUMP_H, 30: rise before an early release is honoured.
REQ-007 Parameter GRAVITY, 6: tenths of a pixel/tick² added per tick.
REQ-008 Parameter INIT_JUMP_VEL, -10: launch velocity at speed 0.
REQ-009 Parameter DROP_VEL, -5: velocity cap on release or max height.
REQ-010 Parameter SPEED_DROP_VEL, 6: fast-fall velocity while ducking mid-air.
REQ-011 Parameter RUN_PERIOD, 10 / DUCK_PERIOD, 20: animation periods in ticks.
REQ-012 Ports: clk in 1 clock; rst_n in 1 async active-low reset; frame_tick in 1 one-cycle pulse per game frame; timer in 6 frame counter 0..59; speed in 4 game speed; jump, duck, crash, restart in 1 each; x_pos out POS_W; y_pos out POS_W; frame out 3 (frame_t); state out 3 (state_t); box_w out 7, box_h out 6 hit-box size.

Function
REQ-013 All registers SHALL update only on cycles with frame_tick=1; outputs are registered and appear the cycle after the tick.
REQ-014 States SHALL be WAITING, RUNNING, JUMPING, DUCKING, CRASHED.
REQ-015 WAITING SHALL go to JUMPING on jump, otherwise hold.
REQ-016 RUNNING SHALL go to JUMPING on jump (jump has priority over duck), to DUCKING on duck, otherwise hold.
REQ-017 DUCKING SHALL go to RUNNING when duck=0 and ignore jump.
REQ-018 On a tick with crash=1 in RUNNING, JUMPING or DUCKING, the state SHALL become CRASHED, overriding every other transition; y_pos and velocity SHALL freeze.
REQ-019 CRASHED SHALL go to RUNNING on restart, with y_pos=GROUND_Y, velocity 0 and accumulator 0; restart in any other state SHALL be ignored.
REQ-020 The launch tick SHALL load vel = INIT_JUMP_VEL - (speed>>3), acc=0 and reached_min=0, and leave y_pos unchanged.
REQ-021 Each later JUMPING tick SHALL set y_pos = y_pos + vel and acc += GRAVITY; if acc ≥ 10, it SHALL subtract 10 and set vel += 1.
REQ-022 reached_min SHALL set when current y_pos < GROUND_Y - MIN_JUMP_H.
REQ-023 If (jump=0 and reached_min) or current y_pos ≤ MAX_JUMP_Y, and vel < DROP_VEL, vel SHALL become DROP_VEL; this overrides the gravity increment that tick.
REQ-024 duck=1 in JUMPING SHALL set vel = SPEED_DROP_VEL when vel < SPEED_DROP_VEL, with priority over REQ-023.
REQ-025 Landing: if y_pos + vel ≥ GROUND_Y, y_pos SHALL clamp to GROUND_Y and vel and acc SHALL clear. The state SHALL become DUCKING if duck=1, else RUNNING. No underflow or wrap below GROUND_Y.
REQ-026 Arithmetic SHALL be signed, with vel sign-extended to POS_W+1 before the add.
REQ-027 frame SHALL follow the next state:
- WAITING: WAITING0 if timer ≥ 30, else WAITING1.
- RUNNING: RUNNING0 if timer mod RUN_PERIOD < RUN_PERIOD/2, else RUNNING1.
- DUCKING: DUCKING0 if timer mod DUCK_PERIOD < DUCK_PERIOD/2, else DUCKING1.
- JUMPING: JUMPING0.
- CRASHED: CRASHED0.
REQ-028 box_w/box_h SHALL be 59/25 in DUCKING, else 44/47.
REQ-029 x_pos SHALL be constant START_X.

Reset
REQ-030 rst_n=0 SHALL asynchronously force, even mid-jump: state=WAITING, frame=WAITING0, x_pos=START_X, y_pos=GROUND_Y, vel=0, acc=0, reached_min=0, box_w=44, box_h=47.
REQ-031 The first tick after deassertion SHALL be processed normally.

Structure
REQ-032 trex_pkg SHALL hold frame_t (WAITING0, WAITING1, RUNNING0, RUNNING1, JUMPING0, DUCKING0, DUCKING1, CRASHED0), state_t, box dimensions and parameter defaults.
REQ-033 Vertical motion (y, vel, acc, reached_min) SHALL live in one sub-module, trex_physics, controlled by launch/step/drop/fastfall/freeze/land strobes from trex_ctrl.

Verification
REQ-034 Jump at speed 0 from ground, held for 4 further ticks -> y_pos 83, 73, 64, 55; vel -8.
REQ-035 Same jump, released on tick 5 -> y_pos 47, vel -5.
REQ-036 Speed 8 jump -> launch vel -11; duck mid-air at vel -7 -> vel 6; landing with duck held -> y_pos 93, state DUCKING, box 59x25.
REQ-037 crash during JUMPING at y 55 -> CRASHED, y_pos held 55, frame CRASHED0; then restart -> RUNNING, y_pos 93.
REQ-038 rst_n pulsed low mid-jump between ticks -> outputs at reset values the same cycle; extra frame_tick-free cycles produce no output change.
